// File: rtl/uart_reg_master.sv
// uart_reg_master: host-side initiator for the UART register-access protocol.
// Takes one parallel read/write request, sends it as a command frame, waits for the
// response frame and returns read data or write acknowledge.
// Optional feature: define UART_REG_MASTER_CHKSUM_EN to append an XOR checksum byte to
// every command frame and require one at the end of every response frame.
module uart_reg_master #(
  parameter int unsigned CLKS_PER_BIT   = 1085,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] BitLast  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HalfLast = CW'(CLKS_PER_BIT / 2 - 1);

  // Index of the last byte of each frame
`ifdef UART_REG_MASTER_CHKSUM_EN
  localparam logic [2:0] WrCmdLast = 3'd5;
  localparam logic [2:0] RdCmdLast = 3'd3;
  localparam logic [2:0] WrRspLast = 3'd1;
  localparam logic [2:0] RdRspLast = 3'd3;
`else
  localparam logic [2:0] WrCmdLast = 3'd4;
  localparam logic [2:0] RdCmdLast = 3'd2;
  localparam logic [2:0] WrRspLast = 3'd0;
  localparam logic [2:0] RdRspLast = 3'd2;
`endif

  typedef enum logic [2:0] {StIdle, StSend, StWaitTx, StRecv, StDone} state_e;

  state_e          state_q, state_d;
  logic            write_q, write_d;
  logic [15:0]     addr_q, addr_d, wdata_q, wdata_d;
  logic [2:0]      idx_q, idx_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      b1_q, b1_d;
`ifdef UART_REG_MASTER_CHKSUM_EN
  logic [7:0]      b2_q, b2_d;
  logic [7:0]      cmd_chk;
`endif
  logic [15:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            ready_en_q;

  logic            tx_start, tx_done;
  logic [7:0]      tx_byte;
  logic            tx_busy_q, tx_busy_d, tx_line_q, tx_line_d;
  logic [8:0]      tx_shift_q, tx_shift_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;

  logic            rx_meta_q, rx_sync_q, rx_valid;
  logic            rx_busy_q, rx_busy_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic [3:0]      rx_bit_q, rx_bit_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;

  assign req_ready = (state_q == StIdle) && ready_en_q;
  assign rsp_valid = (state_q == StDone);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign uart_tx   = tx_line_q;

  // Command byte for the current frame position
  always_comb begin
`ifdef UART_REG_MASTER_CHKSUM_EN
    cmd_chk = (write_q ? 8'h57 : 8'h52) ^ addr_q[15:8] ^ addr_q[7:0] ^
              (write_q ? (wdata_q[15:8] ^ wdata_q[7:0]) : 8'h00);
`endif
    tx_byte = 8'h00;
    case (idx_q)
      3'd0: tx_byte = write_q ? 8'h57 : 8'h52;
      3'd1: tx_byte = addr_q[15:8];
      3'd2: tx_byte = addr_q[7:0];
`ifdef UART_REG_MASTER_CHKSUM_EN
      3'd3: tx_byte = write_q ? wdata_q[15:8] : cmd_chk;
      3'd5: tx_byte = cmd_chk;
`else
      3'd3: tx_byte = wdata_q[15:8];
`endif
      3'd4: tx_byte = wdata_q[7:0];
      default: tx_byte = 8'h00;
    endcase
  end

  // Transmitter: start bit, 8 data bits LSB first, stop bit; tx_done ends the stop bit
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_line_d  = tx_line_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_cnt_d   = tx_cnt_q;
    tx_done    = 1'b0;
    if (!tx_busy_q) begin
      if (tx_start) begin
        tx_busy_d  = 1'b1;
        tx_line_d  = 1'b0;
        tx_shift_d = {1'b1, tx_byte};
        tx_bit_d   = 4'd0;
        tx_cnt_d   = '0;
      end
    end else if (tx_cnt_q == BitLast) begin
      tx_cnt_d = '0;
      if (tx_bit_q == 4'd9) begin
        tx_busy_d = 1'b0;
        tx_line_d = 1'b1;
        tx_done   = 1'b1;
      end else begin
        tx_line_d  = tx_shift_q[0];
        tx_shift_d = {1'b1, tx_shift_q[8:1]};
        tx_bit_d   = tx_bit_q + 4'd1;
      end
    end else begin
      tx_cnt_d = tx_cnt_q + CW'(1);
    end
  end

  // Receiver: start bit checked at mid-bit, then each bit sampled one period later
  always_comb begin
    rx_busy_d = rx_busy_q;
    rx_sh_d   = rx_sh_q;
    rx_bit_d  = rx_bit_q;
    rx_cnt_d  = rx_cnt_q;
    rx_valid  = 1'b0;
    if (!rx_busy_q) begin
      if (!rx_sync_q) begin
        rx_busy_d = 1'b1;
        rx_bit_d  = 4'd0;
        rx_cnt_d  = '0;
      end
    end else if (rx_cnt_q == ((rx_bit_q == 4'd0) ? HalfLast : BitLast)) begin
      rx_cnt_d = '0;
      if (rx_bit_q == 4'd0) begin
        // A start bit that is high again at mid-bit was a glitch
        if (rx_sync_q) rx_busy_d = 1'b0;
        else           rx_bit_d  = 4'd1;
      end else if (rx_bit_q == 4'd9) begin
        rx_busy_d = 1'b0;
        rx_valid  = rx_sync_q;
      end else begin
        rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 4'd1;
      end
    end else begin
      rx_cnt_d = rx_cnt_q + CW'(1);
    end
  end

  // Transaction FSM next-state and response capture
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    b1_d     = b1_q;
`ifdef UART_REG_MASTER_CHKSUM_EN
    b2_d     = b2_q;
`endif
    rdata_d  = rdata_q;
    err_d    = err_q;
    tx_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          idx_d   = 3'd0;
          state_d = StSend;
        end
      end
      StSend: begin
        tx_start = 1'b1;
        state_d  = StWaitTx;
      end
      StWaitTx: begin
        if (tx_done) begin
          if (idx_q == (write_q ? WrCmdLast : RdCmdLast)) begin
            idx_d   = 3'd0;
            tmo_d   = '0;
            state_d = StRecv;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = StSend;
          end
        end
      end
      StRecv: begin
        tmo_d = (tmo_q == TW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + TW'(1);
        if (rx_valid) begin
          if (idx_q == 3'd0 && rx_sh_q != (write_q ? 8'h4B : 8'h44)) begin
            err_d   = 1'b1;
            rdata_d = 16'h0000;
            state_d = StDone;
          end else if (idx_q == (write_q ? WrRspLast : RdRspLast)) begin
            state_d = StDone;
`ifdef UART_REG_MASTER_CHKSUM_EN
            err_d   = rx_sh_q != (write_q ? 8'h4B : (8'h44 ^ b1_q ^ b2_q));
            rdata_d = (write_q || err_d) ? 16'h0000 : {b1_q, b2_q};
`else
            err_d   = 1'b0;
            rdata_d = write_q ? 16'h0000 : {b1_q, rx_sh_q};
`endif
          end else begin
            if (idx_q == 3'd1) b1_d = rx_sh_q;
`ifdef UART_REG_MASTER_CHKSUM_EN
            if (idx_q == 3'd2) b2_d = rx_sh_q;
`endif
            idx_d = idx_q + 3'd1;
          end
        end else if (tmo_q >= TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          rdata_d = 16'h0000;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Serial engine state; line and synchronizer reset to idle-high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_busy_q  <= 1'b0;
      tx_line_q  <= 1'b1;
      tx_shift_q <= '1;
      tx_bit_q   <= '0;
      tx_cnt_q   <= '0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_sh_q    <= '0;
      rx_bit_q   <= '0;
      rx_cnt_q   <= '0;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_line_q  <= tx_line_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_busy_q  <= rx_busy_d;
      rx_sh_q    <= rx_sh_d;
      rx_bit_q   <= rx_bit_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  // Transaction state; ready_en keeps req_ready low until the first edge after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      b1_q       <= '0;
`ifdef UART_REG_MASTER_CHKSUM_EN
      b2_q       <= '0;
`endif
      rdata_q    <= '0;
      err_q      <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      b1_q       <= b1_d;
`ifdef UART_REG_MASTER_CHKSUM_EN
      b2_q       <= b2_d;
`endif
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      ready_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_reg_master.sv
// Directed bench for uart_reg_master: decodes the command line, plays the slave on the
// response line, and checks frames, response data, error flags, timeout and reset.
// Define UART_REG_MASTER_CHKSUM_EN for both files to exercise the checksum build.
module tb_uart_reg_master;

  localparam int unsigned Clks = 8;
  localparam int unsigned Tmo  = 50000;

  logic        clk, rst;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic        uart_tx, uart_rx;

  uart_reg_master #(
    .CLKS_PER_BIT  (Clks),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .uart_tx  (uart_tx),
    .uart_rx  (uart_rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int pulses = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rsp_valid) pulses <= pulses + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Decode bytes from the command line; start_cyc marks the latest start bit
  logic [7:0] txq[$];
  int start_cyc = 0;
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(posedge clk);
      #1;
      if (uart_tx === 1'b0) begin
        start_cyc = cyc;
        repeat (Clks / 2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (Clks) @(posedge clk);
          b[i] = uart_tx;
        end
        repeat (Clks) @(posedge clk);
        txq.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk) uart_rx = 1'b0;
    repeat (Clks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (Clks) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (Clks + 2) @(negedge clk);
  endtask

  // Well-formed slave response, with trailing XOR byte in the checksum build
  task automatic respond(input logic [23:0] bytes, input int n);
    logic [7:0] b, x;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = bytes[8*(n-1-i) +: 8];
      x = x ^ b;
      send_byte(b);
    end
`ifdef UART_REG_MASTER_CHKSUM_EN
    send_byte(x);
`endif
  endtask

  task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d);
    int k;
    k = 0;
    while (!req_ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check_eq("req_ready before request", req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("req_ready drops after accept", req_ready, 1'b0);
  endtask

  // Compare the captured command frame against n hand-computed bytes (+ checksum byte)
  task automatic expect_frame(input string tag, input int n, input logic [47:0] bytes,
                              input logic [7:0] chk);
    int m;
    m = n;
`ifdef UART_REG_MASTER_CHKSUM_EN
    m = n + 1;
`endif
    for (int i = 0; i < m * 20 * Clks; i++) begin
      if (txq.size() >= m) break;
      @(negedge clk);
    end
    check_eq({tag, " frame length"}, txq.size(), m);
    if (txq.size() == m) begin
      for (int i = 0; i < n; i++) check_eq({tag, " cmd byte"}, txq[i], bytes[8*(n-1-i) +: 8]);
`ifdef UART_REG_MASTER_CHKSUM_EN
      check_eq({tag, " cmd checksum"}, txq[n], chk);
`else
      chk = chk;
`endif
    end
    txq.delete();
  endtask

  task automatic wait_rsp(input int limit, input string tag, output int at,
                          output logic [15:0] d, output logic e);
    logic got;
    got = 1'b0;
    at = 0;
    d = 16'hxxxx;
    e = 1'bx;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        at = cyc;
        d = rsp_rdata;
        e = rsp_err;
        break;
      end
    end
    check_eq({tag, " rsp_valid seen"}, got, 1'b1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : main
    int at, p0, t0;
    logic [15:0] d;
    logic e, rdy;
    rst = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset req_ready", req_ready, 1'b0);
    check_eq("reset uart_tx", uart_tx, 1'b1);
    check_eq("reset rsp_valid", rsp_valid, 1'b0);
    check_eq("reset rsp_rdata", rsp_rdata, 16'h0000);
    check_eq("reset rsp_err", rsp_err, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("req_ready after release", req_ready, 1'b1);

    // Write 0x0010 <- 0xA5C3, acknowledged with 0x4B
    p0 = pulses;
    do_req(1'b1, 16'h0010, 16'hA5C3);
    expect_frame("write", 5, 48'h0057_0010_A5C3, 8'h21);
    fork
      respond(24'h00004B, 1);
      begin
        wait_rsp(100 * Clks, "write", at, d, e);
        @(negedge clk);
        rdy = req_ready;
      end
    join
    check_eq("write rsp_err", e, 1'b0);
    check_eq("write rsp_rdata", d, 16'h0000);
    check_eq("write req_ready after rsp", rdy, 1'b1);
    check_eq("write single pulse", pulses - p0, 1);

    // Read 0x0004 answered with 0x1234
    do_req(1'b0, 16'h0004, 16'h0000);
    expect_frame("read", 3, 48'h0000_0052_0004, 8'h56);
    fork
      respond(24'h441234, 3);
      wait_rsp(100 * Clks, "read", at, d, e);
    join
    check_eq("read rsp_err", e, 1'b0);
    check_eq("read rsp_rdata", d, 16'h1234);

    // Read with no answer: timeout exactly Tmo cycles after the last tx done
    do_req(1'b0, 16'h0007, 16'h0000);
    expect_frame("timeout", 3, 48'h0000_0052_0007, 8'h55);
    wait_rsp(Tmo + 200, "timeout", at, d, e);
    check_eq("timeout latency", at - start_cyc, 10 * Clks + Tmo);
    check_eq("timeout rsp_err", e, 1'b1);
    check_eq("timeout rsp_rdata", d, 16'h0000);

    // Bad header: error right after the first response byte, strays ignored
    do_req(1'b0, 16'h0004, 16'h0000);
    expect_frame("badhdr", 3, 48'h0000_0052_0004, 8'h56);
    t0 = cyc;
    fork
      send_byte(8'h99);
      wait_rsp(30 * Clks, "badhdr", at, d, e);
    join
    check_eq("badhdr prompt", (at - t0) <= 11 * Clks, 1'b1);
    check_eq("badhdr rsp_err", e, 1'b1);
    check_eq("badhdr rsp_rdata", d, 16'h0000);
    p0 = pulses;
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (20) @(negedge clk);
    check_eq("stray bytes no pulse", pulses - p0, 0);
    check_eq("stray bytes req_ready", req_ready, 1'b1);
    check_eq("rsp_err holds", rsp_err, 1'b1);

    // Reset during the third byte of a write
    do_req(1'b1, 16'h0020, 16'h1111);
    for (int i = 0; i < 60 * Clks && txq.size() < 2; i++) @(negedge clk);
    for (int i = 0; i < 4 * Clks && uart_tx !== 1'b0; i++) @(negedge clk);
    check_eq("third byte started", uart_tx, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("midreset uart_tx", uart_tx, 1'b1);
    check_eq("midreset req_ready", req_ready, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (12 * Clks) @(negedge clk);
    txq.delete();
    check_eq("post-reset req_ready", req_ready, 1'b1);
    check_eq("post-reset rsp_err", rsp_err, 1'b0);
    do_req(1'b0, 16'h0001, 16'h0000);
    expect_frame("rd after reset", 3, 48'h0000_0052_0001, 8'h53);
    fork
      respond(24'h44BEEF, 3);
      wait_rsp(100 * Clks, "rd after reset", at, d, e);
    join
    check_eq("rd after reset rsp_err", e, 1'b0);
    check_eq("rd after reset rsp_rdata", d, 16'hBEEF);

`ifdef UART_REG_MASTER_CHKSUM_EN
    // Write acknowledged with a wrong checksum byte
    do_req(1'b1, 16'h0010, 16'hA5C3);
    expect_frame("badchk", 5, 48'h0057_0010_A5C3, 8'h21);
    fork
      begin
        send_byte(8'h4B);
        send_byte(8'h00);
      end
      wait_rsp(100 * Clks, "badchk", at, d, e);
    join
    check_eq("badchk rsp_err", e, 1'b1);
    check_eq("badchk rsp_rdata", d, 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
